led_share_arbiter: RTL

//  Shares the 4-bit board LED bank between N_REQ requesters (swinger, status, error, debug sources).

---
 rtl/led_share_arbiter_if.sv | 22 ++
 rtl/led_share_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/led_share_arbiter_if.sv
// LED-bank sharing bus: requester side (REQ/PATTERN) and arbiter side (GNT/DATA/TICK/STATE).
// REQ is a level request with no ready/ack phase; GNT is the only acknowledgement. It is one-hot or zero.
interface led_share_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   REQ;
    logic [4*N_REQ-1:0] PATTERN;
    logic [N_REQ-1:0]   GNT;
    logic [3:0]         DATA;
    logic               TICK;
    logic [1:0]         STATE;   // debug view of the arbiter FSM

    modport master (
        output REQ, PATTERN,
        input  GNT, DATA, TICK, STATE
    );

    modport slave (
        input  REQ, PATTERN,
        output GNT, DATA, TICK, STATE
    );
endinterface

// File: rtl/led_share_arbiter.sv
// Round-robin owner of the 4-bit LED bank with a minimum dwell in prescaler ticks
// and a one-tick blank gap between different owners.
module led_share_arbiter #(
    parameter int         N_REQ          = 4,
    parameter int         PRESCALE_WIDTH = 24,
    parameter int         DWELL_TICKS    = 4,
    parameter logic [3:0] IDLE_PATTERN   = 4'b0000,
    parameter logic [3:0] GAP_PATTERN    = 4'b0000
) (
    input logic                CLK,
    input logic                RSTN,
    led_share_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DW_W  = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                    state;
    logic [PRESCALE_WIDTH-1:0] cnt;
    logic                      tick;
    logic [N_REQ-1:0]          gnt;
    logic [3:0]                data;
    logic [PTR_W-1:0]          ptr;
    logic [DW_W-1:0]           dwell;
    logic                      fresh;   // first cycle of a grant: its TICK is not counted

    logic                      pick_found;
    logic [PTR_W-1:0]          pick_idx;
    logic [PTR_W+1:0]          pick_base;
    logic [PTR_W+1:0]          own_base;
    logic [N_REQ-1:0]          pick_onehot;
    logic                      others_req;
    logic                      owner_req;
    logic                      last_tick;

    // Free-running prescaler; TICK is the registered all-ones decode.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= &cnt;
        end
    end

    always_comb begin : rr_pick
        int j;
        pick_found = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!pick_found && bus.REQ[j]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(j);
            end
        end
    end

    // While holding, the pointer equals the owner, so it doubles as the owner index.
    assign pick_base   = {pick_idx, 2'b00};
    assign own_base    = {ptr, 2'b00};
    assign pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
    assign others_req  = |(bus.REQ & ~gnt);
    assign owner_req   = |(bus.REQ & gnt);
    assign last_tick   = (dwell == DW_W'(DWELL_TICKS - 1));

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state <= ST_IDLE;
            gnt   <= '0;
            data  <= IDLE_PATTERN;
            ptr   <= PTR_W'(N_REQ - 1);
            dwell <= '0;
            fresh <= 1'b0;
        end else begin
            fresh <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state <= ST_HOLD;
                        gnt   <= pick_onehot;
                        data  <= bus.PATTERN[pick_base +: 4];
                        ptr   <= pick_idx;
                        dwell <= '0;
                        fresh <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (tick && !fresh) begin
                        if (last_tick) begin
                            dwell <= '0;
                            if (others_req) begin
                                state <= ST_GAP;
                                gnt   <= '0;
                                data  <= GAP_PATTERN;
                            end else if (owner_req) begin
                                data  <= bus.PATTERN[own_base +: 4];
                                fresh <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                                gnt   <= '0;
                                data  <= IDLE_PATTERN;
                            end
                        end else begin
                            dwell <= dwell + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (pick_found) begin
                            state <= ST_HOLD;
                            gnt   <= pick_onehot;
                            data  <= bus.PATTERN[pick_base +: 4];
                            ptr   <= pick_idx;
                            dwell <= '0;
                            fresh <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            data  <= IDLE_PATTERN;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                    data  <= IDLE_PATTERN;
                end
            endcase
        end
    end

    assign bus.GNT   = gnt;
    assign bus.DATA  = data;
    assign bus.TICK  = tick;
    assign bus.STATE = state;

    a_gnt_onehot0: assert property (@(posedge CLK) $onehot0(gnt));
    a_hold_owned:  assert property (@(posedge CLK) disable iff (!RSTN)
                                    (state == ST_HOLD) |-> (gnt != '0));
endmodule
